pipeline_reduce: RTL and testbench
==================================

Name: pipeline_reduce

Overview:
Parametrised, fully pipelined N-operand reduction unit. It is the successor to the fixed five-operand 5-bit pipeline. It adds configurable width and operand count, a per-transaction operation mode (sum, max, min, saturating sum), and valid/ready handshaking with backpressure. It sits between operand producers and downstream consumers in the datapath and accepts one transaction per cycle when not stalled.

Parameters:
WIDTH, 5, operand width in bits (unsigned), >= 2
N_IN, 5, number of operands per transaction, >= 2
OUT_W, WIDTH+$clog2(N_IN), result width (derived, not overridable)
LAT, $clog2(N_IN)+1, pipeline latency in enabled cycles (derived)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-low reset (asserted when 0)
in_valid  input  1  operand set valid
in_ready  output  1  unit accepts operands this cycle
in_data  input  N_IN*WIDTH  operand i at bits [i*WIDTH +: WIDTH]
in_mode  input  2  0=SUM, 1=MAX, 2=MIN, 3=SAT_SUM
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_data  output  OUT_W  reduction result, zero-extended
out_mode  output  2  mode that produced out_data
busy  output  1  any pipeline stage holds a valid transaction

Behaviour:
- Reset (rst=0, asynchronous): all stage valid bits 0. out_valid=0, out_data=0, out_mode=0, busy=0. in_ready=1 once reset is released. Data registers are also cleared to 0.
- Stage 0 registers operands and mode. Stages 1..$clog2(N_IN) each form one binary tree level. The result is registered at the last stage, so out_data appears LAT enabled cycles after acceptance. Default LAT=4.
- Tree padding: unused leaves get the mode identity: 0 for SUM/SAT_SUM/MAX, all-ones (WIDTH bits) for MIN.
- SUM: exact unsigned sum, never overflows OUT_W.
- MAX/MIN: unsigned compare; the result occupies the low WIDTH bits, upper bits 0.
- SAT_SUM: exact sum computed as for SUM, then clamped at the final stage to 2^WIDTH-1 if it is larger.
- Mode travels with its data through every stage. Mixed modes in flight are legal and independent.
- Enable: en = !out_valid || out_ready. in_ready = en (combinational, depends on out_valid and out_ready only, not on in_valid).
- When en=1, all stages advance by one. Stage 0 loads in_valid && in_ready along with the data.
- When en=0, every stage holds, including data, valid and mode.
- Bubbles are not collapsed; valid=0 slots advance like data.
- out_data and out_mode stay stable while out_valid && !out_ready.
- Transfer rules: in a cycle with in_valid && in_ready, exactly one transaction enters. In a cycle with out_valid && out_ready, exactly one leaves. Both may happen in the same cycle.
- in_data is ignored while in_valid=0; stage data may update but valid stays 0.
- Reset mid-operation: all in-flight transactions are discarded, with no partial output.
- Throughput is 1 per cycle with out_ready held high. Ordering is strictly FIFO.
- busy = OR of all stage valid bits.

Decomposition:
- Package pipeline_pkg holds:
  - typedef enum logic [1:0] mode_e {MODE_SUM, MODE_MAX, MODE_MIN, MODE_SAT_SUM};
  - function identity(mode_e, width) returning the padding value;
  - function combine(mode_e, a, b) implementing the two-input operation.
- One sub-module, reduce_node: a registered two-input combine element with data, mode and valid registers, a hold-on-!en input, and the async active-low clear. The top instantiates a generate tree of reduce_node plus the input stage and the final saturation stage.

Test Plan:
- Reset, then send {6,7,8,3,10} with SUM, out_ready=1 -> out_valid rises exactly 4 cycles after the accept, out_data=34, out_mode=0.
- Back-to-back accepts of {4,8,7,3,1} MAX, then {1,9,6,3,5} MIN, then {8,7,3,7,2} SUM -> outputs in order on consecutive cycles: 8, 1, 27; in_ready stays 1.
- SAT_SUM {31,31,1,0,0} -> 31. Same operands with SUM -> 63 (OUT_W=8).
- Stream 10 transactions and hold out_ready=0 for 5 cycles once out_valid=1 -> in_ready=0, out_data stable, no loss or duplication; all results are checked in order after release.
- Assert rst=0 asynchronously (off a clock edge) with 3 transactions in flight -> out_valid, busy and out_data go to 0 immediately; after release the next input yields its correct result with LAT=4.
- Re-parameterise N_IN=8, WIDTH=8: inputs {255 x8} SUM -> 2040 after LAT=4; MIN with N_IN=3 {9,2,11} -> 2, confirming identity padding.

Source files
------------

// File: rtl/pipeline_reduce_pkg.sv
// Shared mode encoding and two-input reduction primitives for pipeline_reduce.
// Functions work on a fixed 64-bit container; callers cast to their own width.
package pipeline_pkg;

  typedef enum logic [1:0] {MODE_SUM, MODE_MAX, MODE_MIN, MODE_SAT_SUM} mode_e;

  localparam int CW = 64;

  // Padding value that leaves a reduction unchanged.
  function automatic logic [CW-1:0] identity(mode_e m, int width);
    return (m == MODE_MIN) ? ((CW'(1) << width) - CW'(1)) : '0;
  endfunction

  function automatic logic [CW-1:0] combine(mode_e m, logic [CW-1:0] a, logic [CW-1:0] b);
    case (m)
      MODE_MAX: return (a > b) ? a : b;
      MODE_MIN: return (a < b) ? a : b;
      default:  return a + b;
    endcase
  endfunction

endpackage

// File: rtl/pipeline_reduce_node.sv
// One registered tree node: combines two children, carries mode and valid,
// holds while en=0. The root node also applies the SAT_SUM clamp.
module reduce_node
  import pipeline_pkg::*;
#(
  parameter int W     = 8,
  parameter bit CLAMP = 1'b0,
  parameter int SAT_W = W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  mode_e        mode_in,
  input  logic         valid_in,
  output logic [W-1:0] data,
  output mode_e        mode,
  output logic         valid
);

  localparam logic [W-1:0] SAT_MAX = W'((CW'(1) << SAT_W) - CW'(1));

  logic [W-1:0] nxt;

  always_comb begin
    nxt = W'(combine(mode_in, CW'(a), CW'(b)));
    if (CLAMP && mode_in == MODE_SAT_SUM && nxt > SAT_MAX) nxt = SAT_MAX;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data  <= '0;
      mode  <= MODE_SUM;
      valid <= 1'b0;
    end else if (en) begin
      data  <= nxt;
      mode  <= mode_in;
      valid <= valid_in;
    end
  end

endmodule

// File: rtl/pipeline_reduce.sv
// N-operand pipelined reduction: input register stage, then a heap-indexed
// binary tree of reduce_node (node i has children 2i and 2i+1, root is 1).
module pipeline_reduce
  import pipeline_pkg::*;
#(
  parameter  int WIDTH = 5,
  parameter  int N_IN  = 5,
  localparam int OUT_W = WIDTH + $clog2(N_IN),
  localparam int LAT   = $clog2(N_IN) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [1:0]            in_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_W-1:0]      out_data,
  output logic [1:0]            out_mode,
  output logic                  busy
);

  localparam int LEVELS = LAT - 1;
  localparam int P      = 1 << LEVELS;

  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Stage 0: operands widened to OUT_W, spare leaves padded with the identity.
  logic [P-1:0][OUT_W-1:0] leaf, leaf_nxt;
  mode_e                   s0_mode;
  logic                    s0_vld;

  for (genvar g = 0; g < P; g++) begin : g_leaf
    if (g < N_IN) begin : g_op
      assign leaf_nxt[g] = OUT_W'(in_data[g*WIDTH +: WIDTH]);
    end else begin : g_pad
      assign leaf_nxt[g] = OUT_W'(identity(mode_e'(in_mode), WIDTH));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      leaf    <= '0;
      s0_mode <= MODE_SUM;
      s0_vld  <= 1'b0;
    end else if (en) begin
      leaf    <= leaf_nxt;
      s0_mode <= mode_e'(in_mode);
      s0_vld  <= in_valid;
    end
  end

  logic [P-1:1][OUT_W-1:0] nd;
  logic [P-1:1]            nvld;
  mode_e                   nmode [1:P-1];

  for (genvar i = 1; i < P; i++) begin : g_node
    logic [OUT_W-1:0] a, b;
    mode_e            m;
    logic             v;
    if (2*i >= P) begin : g_from_leaf
      assign a = leaf[2*i-P];
      assign b = leaf[2*i+1-P];
      assign m = s0_mode;
      assign v = s0_vld;
    end else begin : g_from_node
      assign a = nd[2*i];
      assign b = nd[2*i+1];
      assign m = nmode[2*i];
      assign v = nvld[2*i];
    end
    reduce_node #(.W(OUT_W), .CLAMP(1'(i == 1)), .SAT_W(WIDTH)) u_node (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .a        (a),
      .b        (b),
      .mode_in  (m),
      .valid_in (v),
      .data     (nd[i]),
      .mode     (nmode[i]),
      .valid    (nvld[i])
    );
  end

  assign out_valid = nvld[1];
  assign out_data  = nd[1];
  assign out_mode  = nmode[1];
  assign busy      = s0_vld | (|nvld);

endmodule

// File: tb/tb_pipeline_reduce.sv
// Directed bench: default 5x5-bit unit plus 8x8-bit and 3x8-bit variants.
module tb_pipeline_reduce;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        a_iv, a_ir, a_ov, a_or, a_busy;
  logic [24:0] a_id;
  logic [1:0]  a_im, a_om;
  logic [7:0]  a_od;

  logic        b_iv, b_ir, b_ov, b_or, b_busy;
  logic [63:0] b_id;
  logic [1:0]  b_im, b_om;
  logic [10:0] b_od;

  logic        c_iv, c_ir, c_ov, c_or, c_busy;
  logic [23:0] c_id;
  logic [1:0]  c_im, c_om;
  logic [9:0]  c_od;

  pipeline_reduce u_a (
    .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id), .in_mode(a_im),
    .out_valid(a_ov), .out_ready(a_or), .out_data(a_od), .out_mode(a_om), .busy(a_busy));

  pipeline_reduce #(.WIDTH(8), .N_IN(8)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id), .in_mode(b_im),
    .out_valid(b_ov), .out_ready(b_or), .out_data(b_od), .out_mode(b_om), .busy(b_busy));

  pipeline_reduce #(.WIDTH(8), .N_IN(3)) u_c (
    .clk(clk), .rst(rst), .in_valid(c_iv), .in_ready(c_ir), .in_data(c_id), .in_mode(c_im),
    .out_valid(c_ov), .out_ready(c_or), .out_data(c_od), .out_mode(c_om), .busy(c_busy));

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [24:0] p5(input int a, input int b, input int c, input int d, input int e);
    return {5'(e), 5'(d), 5'(c), 5'(b), 5'(a)};
  endfunction

  task automatic drive(input int sel, input logic v, input logic [1:0] m, input logic [63:0] d);
    case (sel)
      0: begin a_iv = v; a_im = m; a_id = d[24:0]; end
      1: begin b_iv = v; b_im = m; b_id = d;       end
      default: begin c_iv = v; c_im = m; c_id = d[23:0]; end
    endcase
  endtask

  function automatic logic ov(input int sel);
    return (sel == 0) ? a_ov : (sel == 1) ? b_ov : c_ov;
  endfunction

  function automatic logic [63:0] od(input int sel);
    return (sel == 0) ? 64'(a_od) : (sel == 1) ? 64'(b_od) : 64'(c_od);
  endfunction

  function automatic logic [1:0] om(input int sel);
    return (sel == 0) ? a_om : (sel == 1) ? b_om : c_om;
  endfunction

  // One isolated transaction: checks latency (accept edge counts as 1), data, mode.
  task automatic run(input int sel, input logic [1:0] m, input logic [63:0] d,
                     input logic [63:0] exp, input int lat, input string nm);
    int cyc;
    @(negedge clk);
    drive(sel, 1'b1, m, d);
    @(negedge clk);
    drive(sel, 1'b0, m, d);
    cyc = 1;
    while (!ov(sel) && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check({nm, " latency"}, 64'(cyc), 64'(lat));
    check({nm, " data"}, od(sel), exp);
    check({nm, " mode"}, 64'(om(sel)), 64'(m));
  endtask

  typedef struct {
    logic [1:0]  m;
    logic [24:0] d;
    logic [7:0]  exp;
    string       nm;
  } vec_t;

  vec_t tbl[13];

  initial begin
    int sent, recv, stall_left;
    logic [7:0] held;

    tbl[0]  = '{2'd0, p5(6, 7, 8, 3, 10),      8'd34,  "sum_basic"};
    tbl[1]  = '{2'd1, p5(4, 8, 7, 3, 1),       8'd8,   "max_basic"};
    tbl[2]  = '{2'd2, p5(1, 9, 6, 3, 5),       8'd1,   "min_basic"};
    tbl[3]  = '{2'd0, p5(8, 7, 3, 7, 2),       8'd27,  "sum_b"};
    tbl[4]  = '{2'd3, p5(31, 31, 1, 0, 0),     8'd31,  "sat_clamp"};
    tbl[5]  = '{2'd0, p5(31, 31, 1, 0, 0),     8'd63,  "sum_nosat"};
    tbl[6]  = '{2'd0, p5(31, 31, 31, 31, 31),  8'd155, "sum_allmax"};
    tbl[7]  = '{2'd3, p5(10, 5, 3, 2, 1),      8'd21,  "sat_below"};
    tbl[8]  = '{2'd3, p5(16, 15, 0, 0, 0),     8'd31,  "sat_exact"};
    tbl[9]  = '{2'd2, p5(31, 31, 31, 31, 31),  8'd31,  "min_allones"};
    tbl[10] = '{2'd2, p5(20, 25, 30, 28, 3),   8'd3,   "min_last"};
    tbl[11] = '{2'd1, p5(0, 0, 0, 0, 31),      8'd31,  "max_last"};
    tbl[12] = '{2'd1, p5(0, 0, 0, 0, 0),       8'd0,   "max_zero"};

    drive(0, 1'b0, 2'd0, 64'd0); drive(1, 1'b0, 2'd0, 64'd0); drive(2, 1'b0, 2'd0, 64'd0);
    a_or = 1'b1; b_or = 1'b1; c_or = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst out_valid", 64'(a_ov), 64'd0);
    check("rst busy", 64'(a_busy), 64'd0);
    check("rst out_data", 64'(a_od), 64'd0);
    check("rst out_mode", 64'(a_om), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    check("post-rst in_ready", 64'(a_ir), 64'd1);

    foreach (tbl[i]) run(0, tbl[i].m, 64'(tbl[i].d), 64'(tbl[i].exp), 4, tbl[i].nm);

    // Back-to-back MAX, MIN, SUM with mixed modes in flight
    @(negedge clk);
    drive(0, 1'b1, 2'd1, 64'(p5(4, 8, 7, 3, 1)));
    #1 check("b2b in_ready 0", 64'(a_ir), 64'd1);
    @(negedge clk);
    drive(0, 1'b1, 2'd2, 64'(p5(1, 9, 6, 3, 5)));
    #1 check("b2b in_ready 1", 64'(a_ir), 64'd1);
    @(negedge clk);
    drive(0, 1'b1, 2'd0, 64'(p5(8, 7, 3, 7, 2)));
    #1 check("b2b in_ready 2", 64'(a_ir), 64'd1);
    @(negedge clk);
    a_iv = 1'b0;
    @(negedge clk);
    check("b2b 0 valid", 64'(a_ov), 64'd1);
    check("b2b 0 data", 64'(a_od), 64'd8);
    check("b2b 0 mode", 64'(a_om), 64'd1);
    @(negedge clk);
    check("b2b 1 valid", 64'(a_ov), 64'd1);
    check("b2b 1 data", 64'(a_od), 64'd1);
    check("b2b 1 mode", 64'(a_om), 64'd2);
    @(negedge clk);
    check("b2b 2 valid", 64'(a_ov), 64'd1);
    check("b2b 2 data", 64'(a_od), 64'd27);
    check("b2b 2 mode", 64'(a_om), 64'd0);
    @(negedge clk);
    check("b2b drained", 64'(a_ov), 64'd0);

    // Stream 10 sums (k + 2k + 3 + 0 + 1 = 3k+4) with a 5-cycle backpressure window
    sent = 0; recv = 0; stall_left = -1; held = '0;
    for (int cyc = 0; cyc < 200 && recv < 10; cyc++) begin
      if (stall_left < 0 && a_ov) begin
        stall_left = 5;
        held = a_od;
      end
      a_or = !(stall_left > 0);
      drive(0, sent < 10, 2'd0, 64'(p5(sent, 2 * sent, 3, 0, 1)));
      #1;
      if (stall_left > 0) begin
        check("stall in_ready", 64'(a_ir), 64'd0);
        check("stall data stable", 64'(a_od), 64'(held));
        stall_left--;
      end
      if (a_iv && a_ir) sent++;
      if (a_ov && a_or) begin
        check("stream data", 64'(a_od), 64'(3 * recv + 4));
        recv++;
      end
      @(negedge clk);
    end
    a_iv = 1'b0; a_or = 1'b1;
    check("stream received", 64'(recv), 64'd10);
    repeat (5) @(negedge clk);
    check("stream no dup valid", 64'(a_ov), 64'd0);
    check("stream idle busy", 64'(a_busy), 64'd0);

    // Asynchronous reset with three transactions in flight
    a_or = 1'b0;
    drive(0, 1'b1, 2'd0, 64'(p5(1, 1, 1, 1, 1)));
    @(negedge clk);
    drive(0, 1'b1, 2'd1, 64'(p5(2, 2, 2, 2, 2)));
    @(negedge clk);
    drive(0, 1'b1, 2'd2, 64'(p5(3, 3, 3, 3, 3)));
    @(negedge clk);
    a_iv = 1'b0;
    @(negedge clk);
    check("pre-rst valid", 64'(a_ov), 64'd1);
    check("pre-rst data", 64'(a_od), 64'd5);
    #2 rst = 1'b0;
    #1;
    check("async rst valid", 64'(a_ov), 64'd0);
    check("async rst busy", 64'(a_busy), 64'd0);
    check("async rst data", 64'(a_od), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    a_or = 1'b1;
    run(0, 2'd0, 64'(p5(1, 2, 3, 4, 5)), 64'd15, 4, "after_rst");

    // Wider / other-count variants
    run(1, 2'd0, {8{8'd255}}, 64'd2040, 4, "w8n8_sum");
    run(1, 2'd3, {8{8'd255}}, 64'd255, 4, "w8n8_sat");
    run(1, 2'd1, {8'd3, 8'd200, 8'd7, 8'd0, 8'd9, 8'd201, 8'd1, 8'd2}, 64'd201, 4, "w8n8_max");
    run(2, 2'd2, 64'({8'd11, 8'd2, 8'd9}), 64'd2, 3, "n3_min");
    run(2, 2'd0, 64'({8'd11, 8'd2, 8'd9}), 64'd22, 3, "n3_sum");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
